// File: rtl/flood_reveal_ctrl.sv
// Breadth-first flood-fill reveal sequencer for the minesweeper board store.
// Drives one read port and one reveal-write port; pending cells wait in a FIFO.
module flood_reveal_ctrl #(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] level,
  input  logic       start,
  input  logic [4:0] start_x,
  input  logic [4:0] start_y,
  input  logic       abort,
  output logic       cell_rd,
  output logic [4:0] cell_x,
  output logic [4:0] cell_y,
  input  logic       cell_mine,
  input  logic       cell_revealed,
  input  logic [3:0] cell_count,
  output logic       rev_we,
  output logic       busy,
  output logic       done,
  output logic       mine_hit,
  output logic       overflow,
  output logic [8:0] revealed_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FifoFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSRd, StSChk, StPop, StNRd, StNChk, StDone} state_e;

  state_e        state_q, state_d;
  logic [4:0]    dim_q, dim_d;
  logic [4:0]    sx_q, sx_d, sy_q, sy_d;
  logic [4:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0]    nbr_idx_q, nbr_idx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [8:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [9:0]    fifo_mem [FIFO_DEPTH];

  logic [5:0]    dx, dy, nx, ny;
  logic          nb_in;
  logic          push_req, push_ok;

  // Neighbour offsets as 6-bit two's complement; bit 5 flags a negative coordinate.
  always_comb begin
    dx = 6'd0;
    dy = 6'd0;
    unique case (nbr_idx_q)
      3'd0: begin dx = 6'h3f; dy = 6'h3f; end
      3'd1: begin dx = 6'h3f; dy = 6'd0;  end
      3'd2: begin dx = 6'h3f; dy = 6'd1;  end
      3'd3: begin dx = 6'd0;  dy = 6'h3f; end
      3'd4: begin dx = 6'd0;  dy = 6'd1;  end
      3'd5: begin dx = 6'd1;  dy = 6'h3f; end
      3'd6: begin dx = 6'd1;  dy = 6'd0;  end
      3'd7: begin dx = 6'd1;  dy = 6'd1;  end
    endcase
    nx    = {1'b0, cur_x_q} + dx;
    ny    = {1'b0, cur_y_q} + dy;
    nb_in = !nx[5] && !ny[5] && (nx < {1'b0, dim_q}) && (ny < {1'b0, dim_q});
  end

  // Reveal/mine strobes qualify on the store's registered read data of this cycle.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    cell_rd  = (state_q == StSRd) || ((state_q == StNRd) && nb_in);
    rev_we   = ((state_q == StSChk) && !cell_revealed) ||
               ((state_q == StNChk) && !cell_revealed && !cell_mine);
    mine_hit = (state_q == StSChk) && !cell_revealed && cell_mine;
    cell_x   = 5'd0;
    cell_y   = 5'd0;
    if (state_q == StSRd || state_q == StSChk) begin
      cell_x = sx_q;
      cell_y = sy_q;
    end else if ((state_q == StNRd && nb_in) || state_q == StNChk) begin
      cell_x = nx[4:0];
      cell_y = ny[4:0];
    end
    overflow     = ovf_q;
    revealed_cnt = cnt_q;
    push_req     = rev_we && !cell_mine && (cell_count == 4'd0);
    push_ok      = push_req && (fill_q != FifoFull);
  end

  always_comb begin
    state_d   = state_q;
    dim_d     = dim_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    nbr_idx_d = nbr_idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle: begin
        if (start && level != 2'd0) begin
          state_d  = StSRd;
          dim_d    = (level == 2'd1) ? 5'd8 : (level == 2'd2) ? 5'd10 : 5'd16;
          sx_d     = start_x;
          sy_d     = start_y;
          cnt_d    = 9'd0;
          ovf_d    = 1'b0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          fill_d   = '0;
        end
      end
      StSRd: state_d = StSChk;
      StSChk: begin
        if (!cell_revealed && !cell_mine && cell_count == 4'd0) state_d = StPop;
        else state_d = StDone;
      end
      StPop: begin
        if (fill_q == '0) begin
          state_d = StDone;
        end else begin
          {cur_x_d, cur_y_d} = fifo_mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + AW'(1);
          fill_d    = fill_q - (AW + 1)'(1);
          nbr_idx_d = 3'd0;
          state_d   = StNRd;
        end
      end
      StNRd: begin
        if (nb_in) begin
          state_d = StNChk;
        end else if (nbr_idx_q == 3'd7) begin
          state_d = StPop;
        end else begin
          nbr_idx_d = nbr_idx_q + 3'd1;
        end
      end
      StNChk: begin
        if (nbr_idx_q == 3'd7) begin
          state_d = StPop;
        end else begin
          nbr_idx_d = nbr_idx_q + 3'd1;
          state_d   = StNRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (rev_we && cnt_q != 9'd256) cnt_d = cnt_q + 9'd1;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      fill_d   = fill_q + (AW + 1)'(1);
    end else if (push_req) begin
      ovf_d = 1'b1;
    end

    // Abort wins over every transition; count and overflow are kept for inspection.
    if (abort && state_q != StIdle) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      dim_q     <= 5'd0;
      sx_q      <= 5'd0;
      sy_q      <= 5'd0;
      cur_x_q   <= 5'd0;
      cur_y_q   <= 5'd0;
      nbr_idx_q <= 3'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      cnt_q     <= 9'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dim_q     <= dim_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      nbr_idx_q <= nbr_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {cell_x, cell_y};
  end

endmodule

// File: tb/tb_flood_reveal_ctrl.sv
// Randomized bench for flood_reveal_ctrl: board-store model plus a queue-based BFS reference.
module tb_flood_reveal_ctrl;

  localparam int Budget = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] level;
  logic [4:0] st_x, st_y;
  logic [1:0] start_v, abort_v;
  logic [1:0] rd_v, we_v, busy_v, done_v, mh_v, ovf_v;
  logic [4:0] cx [2];
  logic [4:0] cy [2];
  logic [8:0] rcnt [2];
  logic [1:0] sm_mine = 2'b00;
  logic [1:0] sm_rev = 2'b00;
  logic [3:0] sm_cnt [2] = '{4'd0, 4'd0};

  bit mine [16][16];
  bit rev [2][16][16];
  bit clr = 1'b0;
  int dim_cur = 8;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_seq[$];
  int exp_done, exp_mh, exp_ovf;

  flood_reveal_ctrl #(.FIFO_DEPTH(64)) u_dut (
    .clk(clk), .rst(rst), .level(level), .start(start_v[0]), .start_x(st_x), .start_y(st_y),
    .abort(abort_v[0]), .cell_rd(rd_v[0]), .cell_x(cx[0]), .cell_y(cy[0]),
    .cell_mine(sm_mine[0]), .cell_revealed(sm_rev[0]), .cell_count(sm_cnt[0]),
    .rev_we(we_v[0]), .busy(busy_v[0]), .done(done_v[0]), .mine_hit(mh_v[0]),
    .overflow(ovf_v[0]), .revealed_cnt(rcnt[0])
  );

  flood_reveal_ctrl #(.FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .level(level), .start(start_v[1]), .start_x(st_x), .start_y(st_y),
    .abort(abort_v[1]), .cell_rd(rd_v[1]), .cell_x(cx[1]), .cell_y(cy[1]),
    .cell_mine(sm_mine[1]), .cell_revealed(sm_rev[1]), .cell_count(sm_cnt[1]),
    .rev_we(we_v[1]), .busy(busy_v[1]), .done(done_v[1]), .mine_hit(mh_v[1]),
    .overflow(ovf_v[1]), .revealed_cnt(rcnt[1])
  );

  function automatic int nbr_mines(int x, int y, int d);
    int n = 0;
    for (int ax = x - 1; ax <= x + 1; ax++)
      for (int ay = y - 1; ay <= y + 1; ay++)
        if (!(ax == x && ay == y) && ax >= 0 && ay >= 0 && ax < d && ay < d && mine[ax][ay]) n++;
    return n;
  endfunction

  function automatic int dim_of(int lv);
    return (lv == 1) ? 8 : (lv == 2) ? 10 : 16;
  endfunction

  // Board store: one-cycle read latency, reveal writes land at the clock edge.
  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          rev[0][a][b] <= 1'b0;
          rev[1][a][b] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rd_v[i] && cx[i] < 5'd16 && cy[i] < 5'd16) begin
          sm_mine[i] <= mine[cx[i][3:0]][cy[i][3:0]];
          sm_rev[i]  <= rev[i][cx[i][3:0]][cy[i][3:0]];
          sm_cnt[i]  <= 4'(nbr_mines(int'(cx[i]), int'(cy[i]), dim_cur));
        end
        if (we_v[i] && cx[i] < 5'd16 && cy[i] < 5'd16) rev[i][cx[i][3:0]][cy[i][3:0]] <= 1'b1;
      end
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_board(input int pct, input int d);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mine[a][b] = (a < d && b < d) ? ($urandom_range(0, 99) < pct) : 1'b0;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  // Reference: breadth-first reveal with a bounded queue and the documented cycle costs.
  task automatic run_model(input int inst, input int x0, input int y0, input int d,
                           input int depth);
    bit rv [16][16];
    int q[$];
    int t, c, nxv, nyv;
    int dxs [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dys [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) rv[a][b] = rev[inst][a][b];
    exp_seq.delete();
    exp_mh = 0;
    exp_ovf = 0;
    exp_done = 3;
    if (rv[x0][y0]) return;
    exp_seq.push_back(x0 * 32 + y0);
    rv[x0][y0] = 1'b1;
    if (mine[x0][y0]) begin
      exp_mh = 1;
      return;
    end
    if (nbr_mines(x0, y0, d) != 0) return;
    q.push_back(x0 * 32 + y0);
    t = 3;
    while (q.size() > 0) begin
      c = q.pop_front();
      t++;
      for (int k = 0; k < 8; k++) begin
        nxv = c / 32 + dxs[k];
        nyv = c % 32 + dys[k];
        if (nxv < 0 || nyv < 0 || nxv >= d || nyv >= d) begin
          t += 1;
        end else begin
          t += 2;
          if (!rv[nxv][nyv] && !mine[nxv][nyv]) begin
            rv[nxv][nyv] = 1'b1;
            exp_seq.push_back(nxv * 32 + nyv);
            if (nbr_mines(nxv, nyv, d) == 0) begin
              if (q.size() < depth) q.push_back(nxv * 32 + nyv);
              else exp_ovf = 1;
            end
          end
        end
      end
    end
    exp_done = t + 1;
  endtask

  task automatic click(input int inst, input int x0, input int y0, input int lv,
                       input string tag);
    int d = dim_of(lv);
    int got[$];
    int first_rd = -1, first_we = -1, done_at = -1, mh_at = -1;
    int n_mh = 0, bad_rd = 0, busy_gap = 0, nmis = 0;
    run_model(inst, x0, y0, d, (inst == 0) ? 64 : 4);
    dim_cur = d;
    level = 2'(lv);
    st_x = 5'(x0);
    st_y = 5'(y0);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    for (int c = 1; c <= Budget; c++) begin
      if (c > 1) @(negedge clk);
      if (rd_v[inst]) begin
        if (first_rd < 0) first_rd = c;
        if (int'(cx[inst]) >= d || int'(cy[inst]) >= d) bad_rd++;
      end
      if (we_v[inst]) begin
        got.push_back(int'(cx[inst]) * 32 + int'(cy[inst]));
        if (first_we < 0) first_we = c;
      end
      if (mh_v[inst]) begin
        mh_at = c;
        n_mh++;
      end
      if (!busy_v[inst]) busy_gap++;
      if (done_v[inst]) begin
        done_at = c;
        break;
      end
    end
    for (int k = 0; k < got.size() && k < exp_seq.size(); k++)
      if (got[k] != exp_seq[k]) nmis++;
    check_val({tag, "/first_rd"}, first_rd, 1);
    check_val({tag, "/wr_n"}, got.size(), exp_seq.size());
    check_val({tag, "/wr_seq"}, nmis, 0);
    check_val({tag, "/first_we"}, first_we, (exp_seq.size() > 0) ? 2 : -1);
    check_val({tag, "/done_at"}, done_at, exp_done);
    check_val({tag, "/mine_hit_at"}, mh_at, (exp_mh != 0) ? 2 : -1);
    check_val({tag, "/mine_hit_n"}, n_mh, exp_mh);
    check_val({tag, "/cnt"}, int'(rcnt[inst]), exp_seq.size());
    check_val({tag, "/ovf"}, int'(ovf_v[inst]), exp_ovf);
    check_val({tag, "/bad_rd"}, bad_rd, 0);
    check_val({tag, "/busy_gap"}, busy_gap, 0);
    @(negedge clk);
    check_val({tag, "/after"}, int'({busy_v[inst], done_v[inst], we_v[inst]}), 0);
  endtask

  initial begin
    int n, w, seen_we;
    rst = 1'b0;
    level = 2'd0;
    st_x = 5'd0;
    st_y = 5'd0;
    start_v = 2'b00;
    abort_v = 2'b00;
    #1;
    check_val("rst/ctl", int'({rd_v, we_v, busy_v, done_v, mh_v, ovf_v}), 0);
    check_val("rst/addr", int'({cx[0], cy[0], rcnt[0]}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    set_board(0, 8);
    mine[2][2] = 1'b1;
    mine[4][4] = 1'b1;
    click(0, 3, 3, 1, "count2");

    set_board(0, 8);
    click(0, 0, 0, 1, "free8");
    check_val("free8/cnt64", int'(rcnt[0]), 64);

    set_board(0, 10);
    mine[5][5] = 1'b1;
    click(0, 5, 5, 2, "mine");
    click(0, 5, 5, 2, "already");
    check_val("already/cnt0", int'(rcnt[0]), 0);

    // level 0 click must be ignored
    level = 2'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy_v[0] || rd_v[0]) n++;
      @(negedge clk);
    end
    check_val("lvl0/ignored", n, 0);

    set_board(0, 16);
    click(1, 0, 0, 3, "ovf16");
    check_val("ovf16/sticky", int'(ovf_v[1]), 1);

    for (int b = 0; b < 12; b++) begin
      int lv = $urandom_range(1, 3);
      int d = dim_of(lv);
      set_board($urandom_range(8, 25), d);
      for (int k = 0; k < 3; k++)
        click((b % 4 == 3) ? 1 : 0, $urandom_range(0, d - 1), $urandom_range(0, d - 1), lv,
              $sformatf("rnd%0d_%0d", b, k));
    end

    // abort mid-flood on a mine-free 16x16 board
    set_board(0, 16);
    dim_cur = 16;
    level = 2'd3;
    st_x = 5'd7;
    st_y = 5'd7;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    w = $urandom_range(20, 60);
    seen_we = 0;
    for (int c = 1; c <= w; c++) begin
      if (c > 1) @(negedge clk);
      if (we_v[0]) seen_we++;
    end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check_val("abort/busy", int'(busy_v[0]), 0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (we_v[0] || done_v[0] || rd_v[0]) n++;
      @(negedge clk);
    end
    check_val("abort/quiet", n, 0);
    check_val("abort/cnt", int'(rcnt[0]), seen_we);

    // asynchronous reset during a flood
    set_board(0, 8);
    dim_cur = 8;
    level = 2'd1;
    st_x = 5'd0;
    st_y = 5'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_mid/ctl", int'({rd_v[0], we_v[0], busy_v[0], done_v[0], mh_v[0], ovf_v[0]}),
              0);
    check_val("rst_mid/addr", int'({cx[0], cy[0], rcnt[0]}), 0);
    @(negedge clk);
    rst = 1'b1;
    set_board(0, 8);
    mine[2][2] = 1'b1;
    mine[4][4] = 1'b1;
    click(0, 3, 3, 1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
